// File: rtl/gpu_cmd_issuer.sv
// Command FIFO feeding a GPU through a 4-phase run/ready handshake with a ready timeout.
// Define VBLANK_GATE_EN to start new commands only during vertical blank (vga_vs low).
module gpu_cmd_issuer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [31:0]            push_data,
  input  logic                   push_sprite,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            instruction,
  output logic                   run,
  output logic                   sprite,
  input  logic                   ready,
  input  logic                   vga_vs,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FullCount    = DEPTH[AW:0];
  localparam logic [TW-1:0] TimeoutCount = TIMEOUT[TW-1:0];

  typedef enum logic [1:0] {StIdle, StReq, StRel, StAbort} state_e;

  state_e        state_q;
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [TW-1:0] wait_cnt_q;
  logic          gate_open, pop, push_ok;

`ifdef VBLANK_GATE_EN
  assign gate_open = ~vga_vs;
`else
  logic unused_vga_vs;
  assign unused_vga_vs = vga_vs;
  assign gate_open     = 1'b1;
`endif

  assign full    = (count == FullCount);
  // Holding off while ready is still high keeps a gap after the previous handshake.
  assign pop     = (state_q == StIdle) && (count != '0) && !ready && gate_open;
  assign push_ok = push && (!full || pop);
  assign busy    = (state_q != StIdle) || (count != '0);

  // Storage needs no reset: only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {push_sprite, push_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      run         <= 1'b0;
      instruction <= '0;
      sprite      <= 1'b0;
      wait_cnt_q  <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            {sprite, instruction} <= mem[rd_ptr_q];
            run                   <= 1'b1;
            wait_cnt_q            <= '0;
            state_q               <= StReq;
          end
        end
        StReq: begin
          if (ready) begin
            run     <= 1'b0;
            state_q <= StRel;
          end else if (wait_cnt_q + 1'b1 == TimeoutCount) begin
            run         <= 1'b0;
            timeout_err <= 1'b1;
            state_q     <= StAbort;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StRel, StAbort: begin
          if (!ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
